// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// riscv_pkg : shared decode/EX types (control word, formats, writeback source)
// Rev 1.0
// ============================================================================
package riscv_pkg;

   localparam int XLEN = 32;

   localparam int c_REG_IDX_W     = 5;
   localparam int c_BUBBLE_CNT_W  = 16;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } format_t;

   typedef enum logic [0:0] {
      RD_SRC_ALU = 1'b0,
      RD_SRC_MEM = 1'b1
   } rd_source_t;

   // Field order is MSB first and matches the packed 24-bit word from decode.
   typedef struct packed {
      logic       Reg_writeE;
      logic       ALU_src1;
      logic       JumpE;
      logic       BranchE;
      logic       Mem_Write;
      logic       Load_sign;
      rd_source_t Rd_source;
      logic [3:0] ALU_op;
      logic [1:0] ALU_src2;
      format_t    Format;
      logic [2:0] Memp_size;
      logic [2:0] ComparitorOp;
      logic       isJALR;
      logic       isLUI;
   } ctrl_t;

   localparam int    c_CTRL_W   = $bits(ctrl_t);
   localparam ctrl_t c_CTRL_NOP = '0;

   function automatic logic uses_rs1(input format_t fmt);
      case (fmt)
         FMT_R, FMT_I, FMT_S, FMT_B: return 1'b1;
         default:                    return 1'b0;
      endcase
   endfunction

   function automatic logic uses_rs2(input format_t fmt);
      case (fmt)
         FMT_R, FMT_S, FMT_B: return 1'b1;
         default:             return 1'b0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_register_if.sv
`default_nettype none
// ============================================================================
// id_ex_register_if : ID-side inputs, EX-side outputs and pipeline control
// Rev 1.0
// ============================================================================
interface id_ex_register_if
   import riscv_pkg::*;
#(
   parameter int XLEN = riscv_pkg::XLEN
);

   ctrl_t                           ID_Ctrl_i;
   logic                            ID_Valid_i;
   logic [XLEN-1:0]                 ID_PC_i;
   logic [XLEN-1:0]                 ID_RS1_data_i;
   logic [XLEN-1:0]                 ID_RS2_data_i;
   logic [XLEN-1:0]                 ID_Imm_i;
   logic [c_REG_IDX_W-1:0]          ID_Rs1_i;
   logic [c_REG_IDX_W-1:0]          ID_Rs2_i;
   logic [c_REG_IDX_W-1:0]          ID_Rd_i;
   logic                            Stall_i;
   logic                            Flush_i;

   ctrl_t                           EX_Ctrl_o;
   logic                            EX_Valid_o;
   logic [XLEN-1:0]                 EX_PC_o;
   logic [XLEN-1:0]                 EX_RS1_data_o;
   logic [XLEN-1:0]                 EX_RS2_data_o;
   logic [XLEN-1:0]                 EX_Imm_o;
   logic [c_REG_IDX_W-1:0]          EX_Rs1_o;
   logic [c_REG_IDX_W-1:0]          EX_Rs2_o;
   logic [c_REG_IDX_W-1:0]          EX_Rd_o;
   logic                            Load_use_stall_o;
   logic [c_BUBBLE_CNT_W-1:0]       Bubble_count_o;

   modport master (
      output ID_Ctrl_i, ID_Valid_i, ID_PC_i, ID_RS1_data_i, ID_RS2_data_i,
             ID_Imm_i, ID_Rs1_i, ID_Rs2_i, ID_Rd_i, Stall_i, Flush_i,
      input  EX_Ctrl_o, EX_Valid_o, EX_PC_o, EX_RS1_data_o, EX_RS2_data_o,
             EX_Imm_o, EX_Rs1_o, EX_Rs2_o, EX_Rd_o, Load_use_stall_o,
             Bubble_count_o
   );

   modport slave (
      input  ID_Ctrl_i, ID_Valid_i, ID_PC_i, ID_RS1_data_i, ID_RS2_data_i,
             ID_Imm_i, ID_Rs1_i, ID_Rs2_i, ID_Rd_i, Stall_i, Flush_i,
      output EX_Ctrl_o, EX_Valid_o, EX_PC_o, EX_RS1_data_o, EX_RS2_data_o,
             EX_Imm_o, EX_Rs1_o, EX_Rs2_o, EX_Rd_o, Load_use_stall_o,
             Bubble_count_o
   );

endinterface
`default_nettype wire

// File: rtl/id_ex_register_load_use_detect.sv
`default_nettype none
// ============================================================================
// load_use_detect : flags an ID instruction that reads the register a load in EX writes
// Rev 1.0
// ============================================================================
module load_use_detect
   import riscv_pkg::*;
(
   input  logic                   i_ex_valid,
   input  logic                   i_ex_reg_write,
   input  rd_source_t             i_ex_rd_source,
   input  logic [c_REG_IDX_W-1:0] i_ex_rd,
   input  logic                   i_id_valid,
   input  format_t                i_id_format,
   input  logic [c_REG_IDX_W-1:0] i_id_rs1,
   input  logic [c_REG_IDX_W-1:0] i_id_rs2,
   input  logic                   i_flush,
   output logic                   o_load_use
);

   logic w_ex_is_load;
   logic w_rs1_match;
   logic w_rs2_match;

   // x0 never carries a real result, so a load to x0 cannot create a hazard.
   assign w_ex_is_load = i_ex_valid && i_ex_reg_write &&
                         (i_ex_rd_source == RD_SRC_MEM) &&
                         (i_ex_rd != '0);

   assign w_rs1_match  = uses_rs1(i_id_format) && (i_ex_rd == i_id_rs1);
   assign w_rs2_match  = uses_rs2(i_id_format) && (i_ex_rd == i_id_rs2);

   assign o_load_use   = w_ex_is_load && (w_rs1_match || w_rs2_match) &&
                         i_id_valid && !i_flush;

endmodule
`default_nettype wire

// File: rtl/id_ex_register.sv
`default_nettype none
// ============================================================================
// id_ex_register : ID/EX pipeline register with flush, stall and load-use bubbles
// Rev 1.0
// ============================================================================
module id_ex_register
   import riscv_pkg::*;
#(
   parameter int XLEN = riscv_pkg::XLEN
)(
   input  logic            clk_i,
   input  logic            rst_i,
   id_ex_register_if.slave bus
);

   localparam logic [c_BUBBLE_CNT_W-1:0] c_BUBBLE_MAX = '1;

   ctrl_t                     r_ctrl;
   logic                      r_valid;
   logic [XLEN-1:0]           r_pc;
   logic [XLEN-1:0]           r_rs1_data;
   logic [XLEN-1:0]           r_rs2_data;
   logic [XLEN-1:0]           r_imm;
   logic [c_REG_IDX_W-1:0]    r_rs1;
   logic [c_REG_IDX_W-1:0]    r_rs2;
   logic [c_REG_IDX_W-1:0]    r_rd;
   logic [c_BUBBLE_CNT_W-1:0] r_bubble_cnt;

   logic w_load_use;
   logic w_hold;
   logic w_bubble;
   logic w_count_bubble;

   load_use_detect u_load_use_detect (
      .i_ex_valid     (r_valid),
      .i_ex_reg_write (r_ctrl.Reg_writeE),
      .i_ex_rd_source (r_ctrl.Rd_source),
      .i_ex_rd        (r_rd),
      .i_id_valid     (bus.ID_Valid_i),
      .i_id_format    (bus.ID_Ctrl_i.Format),
      .i_id_rs1       (bus.ID_Rs1_i),
      .i_id_rs2       (bus.ID_Rs2_i),
      .i_flush        (bus.Flush_i),
      .o_load_use     (w_load_use)
   );

   // Flush outranks stall; a load-use bubble only lands when the stage advances.
   assign w_hold         = bus.Stall_i && !bus.Flush_i;
   assign w_bubble       = bus.Flush_i || w_load_use || !bus.ID_Valid_i;
   assign w_count_bubble = w_load_use && !bus.Stall_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ctrl     <= c_CTRL_NOP;
         r_valid    <= 1'b0;
         r_pc       <= '0;
         r_rs1_data <= '0;
         r_rs2_data <= '0;
         r_imm      <= '0;
         r_rs1      <= '0;
         r_rs2      <= '0;
         r_rd       <= '0;
      end else if (!w_hold) begin
         if (w_bubble) begin
            r_ctrl     <= c_CTRL_NOP;
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
         end else begin
            r_ctrl     <= bus.ID_Ctrl_i;
            r_valid    <= 1'b1;
            r_pc       <= bus.ID_PC_i;
            r_rs1_data <= bus.ID_RS1_data_i;
            r_rs2_data <= bus.ID_RS2_data_i;
            r_imm      <= bus.ID_Imm_i;
            r_rs1      <= bus.ID_Rs1_i;
            r_rs2      <= bus.ID_Rs2_i;
            r_rd       <= bus.ID_Rd_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_bubble_cnt <= '0;
      end else if (w_count_bubble && (r_bubble_cnt != c_BUBBLE_MAX)) begin
         r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
   end

   assign bus.EX_Ctrl_o        = r_ctrl;
   assign bus.EX_Valid_o       = r_valid;
   assign bus.EX_PC_o          = r_pc;
   assign bus.EX_RS1_data_o    = r_rs1_data;
   assign bus.EX_RS2_data_o    = r_rs2_data;
   assign bus.EX_Imm_o         = r_imm;
   assign bus.EX_Rs1_o         = r_rs1;
   assign bus.EX_Rs2_o         = r_rs2;
   assign bus.EX_Rd_o          = r_rd;
   assign bus.Load_use_stall_o = w_load_use;
   assign bus.Bubble_count_o   = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_register.sv
`default_nettype none
// ============================================================================
// tb_id_ex_register : directed vectors for the ID/EX register
// Rev 1.0
// ============================================================================
module tb_id_ex_register;
   import riscv_pkg::*;

   logic clk;
   logic rst;

   int n_vec;
   int n_err;

   ctrl_t add_c, lw_c, addi_c, sw_c, lui_c;

   id_ex_register_if #(.XLEN(32)) bus ();

   id_ex_register #(.XLEN(32)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_id(input ctrl_t c, input logic v, input int pc,
                           input int rs1, input int rs2, input int rd, input int imm);
      bus.ID_Ctrl_i     = c;
      bus.ID_Valid_i    = v;
      bus.ID_PC_i       = 32'(pc);
      bus.ID_RS1_data_i = 32'(pc + 32'h100);
      bus.ID_RS2_data_i = 32'(pc + 32'h200);
      bus.ID_Imm_i      = 32'(imm);
      bus.ID_Rs1_i      = 5'(rs1);
      bus.ID_Rs2_i      = 5'(rs2);
      bus.ID_Rd_i       = 5'(rd);
   endtask

   task automatic expect_ex(input string tag, input ctrl_t c, input int pc,
                            input int rs1, input int rs2, input int rd, input int imm);
      check({tag, "_valid"}, 32'(bus.EX_Valid_o),    32'd1);
      check({tag, "_ctrl"},  32'(bus.EX_Ctrl_o),     32'(c));
      check({tag, "_pc"},    bus.EX_PC_o,            32'(pc));
      check({tag, "_rs1d"},  bus.EX_RS1_data_o,      32'(pc + 32'h100));
      check({tag, "_rs2d"},  bus.EX_RS2_data_o,      32'(pc + 32'h200));
      check({tag, "_imm"},   bus.EX_Imm_o,           32'(imm));
      check({tag, "_rs1"},   32'(bus.EX_Rs1_o),      32'(rs1));
      check({tag, "_rs2"},   32'(bus.EX_Rs2_o),      32'(rs2));
      check({tag, "_rd"},    32'(bus.EX_Rd_o),       32'(rd));
   endtask

   task automatic expect_bubble(input string tag);
      check({tag, "_valid"}, 32'(bus.EX_Valid_o),    32'd0);
      check({tag, "_ctrl"},  32'(bus.EX_Ctrl_o),     32'd0);
      check({tag, "_pc"},    bus.EX_PC_o,            32'd0);
      check({tag, "_rs1d"},  bus.EX_RS1_data_o,      32'd0);
      check({tag, "_rs2d"},  bus.EX_RS2_data_o,      32'd0);
      check({tag, "_imm"},   bus.EX_Imm_o,           32'd0);
      check({tag, "_rd"},    32'(bus.EX_Rd_o),       32'd0);
   endtask

   task automatic check_cnt(input string tag, input int exp);
      check(tag, 32'(bus.Bubble_count_o), 32'(exp));
   endtask

   task automatic check_lus(input string tag, input logic exp);
      check(tag, 32'(bus.Load_use_stall_o), 32'(exp));
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;

      add_c  = '0; add_c.Reg_writeE  = 1'b1; add_c.Format  = FMT_R;
      lw_c   = '0; lw_c.Reg_writeE   = 1'b1; lw_c.Format   = FMT_I; lw_c.Rd_source = RD_SRC_MEM;
      lw_c.ALU_src2 = 2'b01; lw_c.Memp_size = 3'b010; lw_c.Load_sign = 1'b1;
      addi_c = '0; addi_c.Reg_writeE = 1'b1; addi_c.Format = FMT_I; addi_c.ALU_src2 = 2'b01;
      sw_c   = '0; sw_c.Mem_Write    = 1'b1; sw_c.Format   = FMT_S; sw_c.ALU_src2 = 2'b01;
      sw_c.Memp_size = 3'b010;
      lui_c  = '0; lui_c.Reg_writeE  = 1'b1; lui_c.Format  = FMT_U; lui_c.isLUI = 1'b1;
      lui_c.ALU_src2 = 2'b10; lui_c.ALU_op = 4'hA;

      // reset wins over stall and flush
      rst = 1'b1; bus.Stall_i = 1'b1; bus.Flush_i = 1'b1;
      drive_id(add_c, 1'b1, 100, 1, 2, 3, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      expect_bubble("reset");
      check_cnt("reset_cnt", 0);
      check_lus("reset_lus", 1'b0);

      // ADD x3,x1,x2 plain flow
      rst = 1'b0; bus.Stall_i = 1'b0; bus.Flush_i = 1'b0;
      tick();
      expect_ex("add", add_c, 100, 1, 2, 3, 0);

      // LW x5 then ADD x6,x5,x1: one bubble
      drive_id(lw_c, 1'b1, 104, 1, 8, 5, 8);
      #1 check_lus("lw_lus", 1'b0);
      tick();
      expect_ex("lw", lw_c, 104, 1, 8, 5, 8);
      drive_id(add_c, 1'b1, 108, 5, 1, 6, 0);
      #1 check_lus("hz_lus", 1'b1);
      tick();
      expect_bubble("hz_bubble");
      check_cnt("hz_cnt", 1);
      #1 check_lus("hz_lus_clear", 1'b0);
      tick();
      expect_ex("hz_add", add_c, 108, 5, 1, 6, 0);

      // false hazard: ADDI rs2 field matches but I-format ignores rs2
      drive_id(lw_c, 1'b1, 112, 1, 0, 5, 0);
      tick();
      drive_id(addi_c, 1'b1, 116, 7, 5, 6, 5);
      #1 check_lus("addi_lus", 1'b0);
      tick();
      expect_ex("addi", addi_c, 116, 7, 5, 6, 5);

      // LW x0 then ADD x6,x0,x0
      drive_id(lw_c, 1'b1, 120, 1, 0, 0, 0);
      tick();
      drive_id(add_c, 1'b1, 124, 0, 0, 6, 0);
      #1 check_lus("x0_lus", 1'b0);
      tick();
      expect_ex("x0_add", add_c, 124, 0, 0, 6, 0);
      check_cnt("x0_cnt", 1);

      // store reading a load result through rs2 only
      drive_id(lw_c, 1'b1, 128, 2, 0, 9, 4);
      tick();
      drive_id(sw_c, 1'b1, 132, 2, 9, 0, 12);
      #1 check_lus("sw_lus", 1'b1);
      tick();
      expect_bubble("sw_bubble");
      check_cnt("sw_cnt", 2);
      tick();
      expect_ex("sw", sw_c, 132, 2, 9, 0, 12);

      // LUI ignores rs1 field
      drive_id(lw_c, 1'b1, 136, 1, 0, 9, 0);
      tick();
      drive_id(lui_c, 1'b1, 140, 9, 9, 10, 32'h12345000);
      #1 check_lus("lui_lus", 1'b0);
      tick();
      expect_ex("lui", lui_c, 140, 9, 9, 10, 32'h12345000);

      // flush masks the hazard and beats stall
      drive_id(lw_c, 1'b1, 144, 1, 0, 5, 0);
      tick();
      drive_id(add_c, 1'b1, 148, 5, 1, 6, 0);
      #1 check_lus("fl_pre_lus", 1'b1);
      bus.Flush_i = 1'b1; bus.Stall_i = 1'b1;
      #1 check_lus("fl_lus", 1'b0);
      tick();
      expect_bubble("flush");
      check_cnt("flush_cnt", 2);

      // stall holds for three cycles
      bus.Flush_i = 1'b0; bus.Stall_i = 1'b0;
      drive_id(add_c, 1'b1, 152, 1, 2, 3, 0);
      tick();
      expect_ex("pre_stall", add_c, 152, 1, 2, 3, 0);
      bus.Stall_i = 1'b1;
      drive_id(addi_c, 1'b1, 156, 7, 5, 6, 5);
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_ex("stall_hold", add_c, 152, 1, 2, 3, 0);
      end

      // hazard seen during stall, bubble only once stall drops
      bus.Stall_i = 1'b0;
      drive_id(lw_c, 1'b1, 160, 1, 0, 5, 0);
      tick();
      bus.Stall_i = 1'b1;
      drive_id(add_c, 1'b1, 164, 5, 1, 6, 0);
      #1 check_lus("st_lus", 1'b1);
      tick();
      expect_ex("st_hold_lw", lw_c, 160, 1, 0, 5, 0);
      check_cnt("st_cnt_hold", 2);
      bus.Stall_i = 1'b0;
      tick();
      expect_bubble("st_bubble");
      check_cnt("st_cnt", 3);

      // invalid ID captured as bubble
      drive_id(add_c, 1'b0, 168, 1, 2, 3, 0);
      tick();
      expect_bubble("invalid");

      // reset mid-stall discards EX and counter
      drive_id(add_c, 1'b1, 172, 1, 2, 3, 0);
      tick();
      bus.Stall_i = 1'b1; rst = 1'b1;
      tick();
      expect_bubble("rst_stall");
      check_cnt("rst_stall_cnt", 0);
      rst = 1'b0; bus.Stall_i = 1'b0;
      tick();
      expect_ex("post_rst", add_c, 172, 1, 2, 3, 0);

      // saturation near the top of the counter range
      force dut.r_bubble_cnt = 16'hFFFD;
      #1 release dut.r_bubble_cnt;
      check_cnt("sat_preload", 32'hFFFD);
      for (int i = 0; i < 3; i++) begin
         drive_id(lw_c, 1'b1, 200, 1, 0, 5, 0);
         tick();
         drive_id(add_c, 1'b1, 204, 5, 1, 6, 0);
         tick();
         check_cnt("sat_cnt", (i == 0) ? 32'hFFFE : 32'hFFFF);
      end
      bus.Stall_i = 1'b1; rst = 1'b1;
      tick();
      expect_bubble("sat_rst");
      check_cnt("sat_rst_cnt", 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
